sos_cascade: RTL

- Time-multiplexed cascade of N_STAGES second-order IIR sections (transposed direct form II), shared across CHANNELS interleaved audio channels.
- Generalises the single-section filter to multiple stages and channels, with runtime coefficient loading, a valid/ready handshake, final gain and output saturation.
- Sits between the sample-rate trigger/ADC deserialiser and the DAC serialiser in the audio path.
- Uses a single multiplier.

---
 rtl/sos_cascade.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sos_cascade.sv
// Purpose: cascade of N_STAGES transposed-DF-II biquads time-shared over CHANNELS
//          channels, using one multiplier, runtime coefficients, final gain and saturation.
// Ports:   clk/reset (sync, active-high); in_* valid/ready sample input; out_* valid/ready
//          result with channel and saturation flag; coef_* coefficient write port;
//          state_clr clears all delay state; busy is high while a sample is being computed.
// Latency: out_valid rises 5*N_STAGES+2 clocks after the accepting edge (accept edge is clock 1).
module sos_cascade #(
  parameter int  DATA_W   = 24,
  parameter int  COEF_W   = 16,
  parameter int  N_STAGES = 4,
  parameter int  CHANNELS = 2,
  parameter int  GUARD    = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CA_W     = $clog2(5*N_STAGES+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [CA_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              state_clr,
  output logic              busy
);
  localparam int FRAC   = COEF_W - 2;
  localparam int ACC_W  = DATA_W + COEF_W + GUARD;
  localparam int P_W    = DATA_W + COEF_W;
  localparam int W_W    = ACC_W + 2;  // wide enough for any sum/difference before clamping
  localparam int N_COEF = 5*N_STAGES + 1;
  localparam int SW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [2:0] {IDLE, MB0, MB1, MA1, MB2, MA2, GAIN, HOLD} state_t;

  // Clamp helpers: result is {clamped_flag, value}.
  function automatic logic [DATA_W:0] clamp_data(input logic signed [W_W-1:0] v);
    logic [W_W-DATA_W:0] top;
    top = v[W_W-1:DATA_W-1];
    if (&top || ~|top) clamp_data = {1'b0, v[DATA_W-1:0]};
    else               clamp_data = {1'b1, v[W_W-1], {(DATA_W-1){~v[W_W-1]}}};
  endfunction

  function automatic logic [ACC_W:0] clamp_acc(input logic signed [W_W-1:0] v);
    logic [W_W-ACC_W:0] top;
    top = v[W_W-1:ACC_W-1];
    if (&top || ~|top) clamp_acc = {1'b0, v[ACC_W-1:0]};
    else               clamp_acc = {1'b1, v[W_W-1], {(ACC_W-1){~v[W_W-1]}}};
  endfunction

  // b0 of every stage and the gain (also at a multiple of 5) reset to 1.0.
  function automatic logic [COEF_W-1:0] coef_rst(input int i);
    coef_rst = ((i % 5) == 0) ? COEF_W'(1 << FRAC) : '0;
  endfunction

  state_t                   state_q, state_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [CH_W-1:0]          chan_q, chan_d;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [W_W-1:0]    acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic                     clr_pend_q, clr_pend_d;
  logic                     pend_we_q, pend_we_d;
  logic [CA_W-1:0]          pend_addr_q, pend_addr_d;
  logic [COEF_W-1:0]        pend_dat_q, pend_dat_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]          out_chan_q, out_chan_d;
  logic                     out_sat_q, out_sat_d;
  logic [COEF_W-1:0]        coef_q [N_COEF];
  logic [COEF_W-1:0]        coef_d [N_COEF];
  logic signed [ACC_W-1:0]  s1_q [CHANNELS][N_STAGES];
  logic signed [ACC_W-1:0]  s1_d [CHANNELS][N_STAGES];
  logic signed [ACC_W-1:0]  s2_q [CHANNELS][N_STAGES];
  logic signed [ACC_W-1:0]  s2_d [CHANNELS][N_STAGES];

  // Shared multiplier: coefficient selected by state, times x or y.
  logic [CA_W-1:0]          cbase;
  logic [COEF_W-1:0]        mul_a;
  logic [DATA_W-1:0]        mul_b;
  logic signed [P_W-1:0]    prod;
  logic signed [W_W-1:0]    prod_w, s1_w, s2_w, sum_b0, sum_b1, dif_a;
  logic [DATA_W:0]          y_clamp, g_clamp;
  logic [ACC_W:0]           s_clamp;

  assign cbase = CA_W'(stage_q) * CA_W'(5);

  always_comb begin
    mul_a = coef_q[cbase];
    mul_b = x_q;
    case (state_q)
      MB1:     mul_a = coef_q[cbase + CA_W'(1)];
      MA1:     begin mul_a = coef_q[cbase + CA_W'(3)]; mul_b = y_q; end
      MB2:     mul_a = coef_q[cbase + CA_W'(2)];
      MA2:     begin mul_a = coef_q[cbase + CA_W'(4)]; mul_b = y_q; end
      GAIN:    mul_a = coef_q[CA_W'(N_COEF-1)];
      default: ;
    endcase
  end

  assign prod    = $signed({{(P_W-COEF_W){mul_a[COEF_W-1]}}, mul_a}) *
                   $signed({{(P_W-DATA_W){mul_b[DATA_W-1]}}, mul_b});
  assign prod_w  = $signed({{(W_W-P_W){prod[P_W-1]}}, prod});
  assign s1_w    = $signed({{(W_W-ACC_W){s1_q[chan_q][stage_q][ACC_W-1]}}, s1_q[chan_q][stage_q]});
  assign s2_w    = $signed({{(W_W-ACC_W){s2_q[chan_q][stage_q][ACC_W-1]}}, s2_q[chan_q][stage_q]});
  assign sum_b0  = prod_w + s1_w;
  assign sum_b1  = prod_w + s2_w;
  assign dif_a   = acc_q - prod_w;
  assign y_clamp = clamp_data(sum_b0 >>> FRAC);
  assign g_clamp = clamp_data(prod_w >>> FRAC);
  assign s_clamp = clamp_acc(dif_a);

  assign busy      = (state_q != IDLE) && (state_q != HOLD);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    chan_d      = chan_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    clr_pend_d  = clr_pend_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    coef_d      = coef_q;
    s1_d        = s1_q;
    s2_d        = s2_q;

    // A write on the accepting edge is parked until the sample finishes so the
    // sample runs on the old coefficient set.
    if (coef_we && !busy && (coef_addr <= CA_W'(N_COEF-1))) begin
      if (state_q == IDLE && in_valid) begin
        pend_we_d   = 1'b1;
        pend_addr_d = coef_addr;
        pend_dat_d  = coef_wdata;
      end else begin
        coef_d[coef_addr] = coef_wdata;
      end
    end

    // State clear is held off while a sample is in flight.
    if (busy) begin
      clr_pend_d = clr_pend_q | state_clr;
    end else begin
      clr_pend_d = 1'b0;
      if (state_clr || clr_pend_q) begin
        for (int c = 0; c < CHANNELS; c++) begin
          for (int s = 0; s < N_STAGES; s++) begin
            s1_d[c][s] = '0;
            s2_d[c][s] = '0;
          end
        end
      end
    end

    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = in_data;
        chan_d  = (int'(in_chan) < CHANNELS) ? in_chan : '0;
        stage_d = '0;
        sat_d   = 1'b0;
        state_d = MB0;
      end
      MB0: begin
        y_d     = y_clamp[DATA_W-1:0];
        sat_d   = sat_q | y_clamp[DATA_W];
        state_d = MB1;
      end
      MB1: begin
        acc_d   = sum_b1;
        state_d = MA1;
      end
      MA1: begin
        s1_d[chan_q][stage_q] = s_clamp[ACC_W-1:0];
        sat_d   = sat_q | s_clamp[ACC_W];
        state_d = MB2;
      end
      MB2: begin
        acc_d   = prod_w;
        state_d = MA2;
      end
      MA2: begin
        s2_d[chan_q][stage_q] = s_clamp[ACC_W-1:0];
        sat_d = sat_q | s_clamp[ACC_W];
        x_d   = y_q;
        if (stage_q == SW'(N_STAGES-1)) begin
          state_d = GAIN;
        end else begin
          stage_d = stage_q + SW'(1);
          state_d = MB0;
        end
      end
      GAIN: begin
        out_data_d = g_clamp[DATA_W-1:0];
        out_sat_d  = sat_q | g_clamp[DATA_W];
        out_chan_d = chan_q;
        if (pend_we_q) coef_d[pend_addr_q] = pend_dat_q;
        pend_we_d  = 1'b0;
        state_d    = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      chan_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      clr_pend_q  <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < N_COEF; i++) coef_q[i] <= coef_rst(i);
      for (int c = 0; c < CHANNELS; c++) begin
        for (int s = 0; s < N_STAGES; s++) begin
          s1_q[c][s] <= '0;
          s2_q[c][s] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      chan_q      <= chan_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      clr_pend_q  <= clr_pend_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sat_q   <= out_sat_d;
      coef_q      <= coef_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end
endmodule
